// File: rtl/uart_pkg.sv
// Shared types for the UART blocks: FSM state and parity-mode enums, legal
// frame-width range and small parity helpers.
package uart_pkg;

    localparam int UART_DATA_BITS_MIN = 5;
    localparam int UART_DATA_BITS_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_e;

    function automatic uart_parity_e decode_parity(input logic [1:0] mode);
        uart_parity_e res;
        case (mode)
            2'b01:   res = PAR_EVEN;
            2'b10:   res = PAR_ODD;
            default: res = PAR_NONE;
        endcase
        return res;
    endfunction

    // Starting value of the running XOR so that it ends as the parity bit to send.
    function automatic logic parity_seed(input uart_parity_e mode);
        return (mode == PAR_ODD) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Writes while full and reads while empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two, at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests against the registered flags and compute next occupancy
    always_comb begin
        push_s = wr_en && !full_r;
        pop_s  = rd_en && !empty_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 1'b1;
            2'b01:   count_s = count_r - 1'b1;
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_CNT);
            empty_r <= (count_s == {(AW + 1){1'b0}});
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: TX FIFO feeding a start/data/parity/stop framer.
// The parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_2,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BIT_W = $clog2(UART_DATA_BITS_MAX);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    if ((DATA_BITS < UART_DATA_BITS_MIN) || (DATA_BITS > UART_DATA_BITS_MAX)) begin : g_bad_data_bits
        $error("uart_tx_buffered: DATA_BITS out of range");
    end

    uart_tx_state_e         state_r;
    uart_tx_state_e         state_s;
    uart_tx_state_e         adv_state_s;
    logic [DIV_W-1:0]       baud_cnt_r;
    logic [DIV_W-1:0]       baud_cnt_s;
    logic [DIV_W-1:0]       div_r;
    logic [DIV_W-1:0]       div_s;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [BIT_W-1:0]       bit_cnt_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   shift_s;
    logic                   stop2_r;
    logic                   stop2_s;
    logic                   serial_r;
    logic                   serial_s;
    logic                   busy_r;
    logic                   tx_done_r;
    logic                   done_next_s;
    logic                   final_stop_s;
    logic                   bit_end_s;
    logic                   frame_end_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [DATA_BITS-1:0]   fifo_head_s;
`ifdef UART_TX_PARITY_EN
    uart_parity_e           par_mode_r;
    uart_parity_e           par_mode_s;
    logic                   parity_r;
    logic                   parity_s;
`else
    logic                   unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    // Frame sequencing, datapath updates and the next serial line level
    always_comb begin
        adv_state_s = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        div_s       = div_r;
        stop2_s     = stop2_r;
        frame_end_s = 1'b0;
        bit_end_s   = (baud_cnt_r == div_r);
`ifdef UART_TX_PARITY_EN
        par_mode_s  = par_mode_r;
        parity_s    = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                adv_state_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) begin
                    adv_state_s = ST_DATA;
                    bit_cnt_s   = {BIT_W{1'b0}};
                end else begin
                    adv_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
`ifdef UART_TX_PARITY_EN
                    parity_s = parity_r ^ shift_r[0];
`endif
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        adv_state_s = (par_mode_r != PAR_NONE) ? ST_PARITY : ST_STOP1;
`else
                        adv_state_s = ST_STOP1;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + 1'b1;
                    end
                end else begin
                    adv_state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    adv_state_s = ST_STOP1;
                end else begin
                    adv_state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP1: begin
                if (bit_end_s && stop2_r) begin
                    adv_state_s = ST_STOP2;
                end else if (bit_end_s) begin
                    adv_state_s = ST_IDLE;
                    frame_end_s = 1'b1;
                end else begin
                    adv_state_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (bit_end_s) begin
                    adv_state_s = ST_IDLE;
                    frame_end_s = 1'b1;
                end else begin
                    adv_state_s = ST_STOP2;
                end
            end
            default: begin
                adv_state_s = ST_IDLE;
            end
        endcase

        // A queued byte starts straight from the last stop bit, so frames chain without a gap.
        pop_s = ((state_r == ST_IDLE) || frame_end_s) && !fifo_empty_s;
        if (pop_s) begin
            state_s = ST_START;
            shift_s = fifo_head_s;
            div_s   = baud_div;
            stop2_s = stop_2;
`ifdef UART_TX_PARITY_EN
            par_mode_s = decode_parity(parity_mode);
            parity_s   = parity_seed(par_mode_s);
`endif
        end else begin
            state_s = adv_state_s;
        end

        if ((state_r == ST_IDLE) || bit_end_s) begin
            baud_cnt_s = {DIV_W{1'b0}};
        end else begin
            baud_cnt_s = baud_cnt_r + 1'b1;
        end

        case (state_s)
            ST_IDLE:   serial_s = 1'b1;
            ST_START:  serial_s = 1'b0;
            ST_DATA:   serial_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_s = parity_s;
`endif
            ST_STOP1:  serial_s = 1'b1;
            ST_STOP2:  serial_s = 1'b1;
            default:   serial_s = 1'b1;
        endcase

        final_stop_s = (state_s == ST_STOP2) || ((state_s == ST_STOP1) && !stop2_s);
        done_next_s  = final_stop_s && (baud_cnt_s == div_s);
    end

    // Frame state and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {DIV_W{1'b0}};
            div_r      <= {DIV_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            stop2_r    <= 1'b0;
            serial_r   <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_mode_r <= PAR_NONE;
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            div_r      <= div_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            stop2_r    <= stop2_s;
            serial_r   <= serial_s;
            busy_r     <= (state_s != ST_IDLE);
            tx_done_r  <= done_next_s;
`ifdef UART_TX_PARITY_EN
            par_mode_r <= par_mode_s;
            parity_r   <= parity_s;
`endif
        end
    end

    assign wr_ready   = !fifo_full_s;
    assign serial_out = serial_r;
    assign busy       = busy_r;
    assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and randomized bench for uart_tx_buffered; expected line waveforms
// are built per frame from the data, divider, parity mode and stop count.
module tb_uart_tx_buffered;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DIV_W-1:0]      baud_div = 16'd0;
    logic [1:0]            parity_mode = 2'b00;
    logic                  stop_2 = 1'b0;
    logic                  wr_valid = 1'b0;
    logic [DATA_BITS-1:0]  wr_data = 8'h00;
    logic                  wr_ready;
    logic                  serial_out;
    logic                  busy;
    logic                  tx_done;
    logic [2:0]            fifo_count;

    int checks   = 0;
    int failures = 0;

    uart_tx_buffered #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop_2      (stop_2),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .serial_out  (serial_out),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit par_on(input logic [1:0] m);
        bit en;
        en = 1'b0;
`ifdef UART_TX_PARITY_EN
        en = 1'b1;
`endif
        return en && ((m == 2'b01) || (m == 2'b10));
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_serial"}, 32'(serial_out), 32'd1);
        check({tag, "_busy"},   32'(busy),       32'd0);
        check({tag, "_done"},   32'(tx_done),    32'd0);
    endtask

    // Called at the negedge inside the first START cycle; returns at the negedge after the frame.
    task automatic check_frame(input logic [7:0] d, input int div, input logic [1:0] m, input logic s2);
        logic q[$];
        int   n;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par_on(m)) q.push_back((m == 2'b10) ? ~(^d) : (^d));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        n = q.size();
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c <= div; c++) begin
                check("serial_out", 32'(serial_out), 32'(q[b]));
                check("busy", 32'(busy), 32'd1);
                check("tx_done", 32'(tx_done), 32'((b == n - 1) && (c == div)));
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while ((serial_out !== 1'b0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(serial_out), 32'd0);
    endtask

    // Idle, empty FIFO, called at a negedge.
    task automatic send_and_check(input logic [7:0] d, input int div, input logic [1:0] m, input logic s2);
        baud_div    = DIV_W'(div);
        parity_mode = m;
        stop_2      = s2;
        wr_data     = d;
        wr_valid    = 1'b1;
        check("wr_ready_idle", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        check("line_before_pop", 32'(serial_out), 32'd1);
        check("count_after_write", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("count_after_pop", 32'(fifo_count), 32'd0);
        check_frame(d, div, m, s2);
        check_idle("after_frame");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        logic [7:0] fd [6];
        int         acc_edge [6];
        logic [7:0] d1;
        logic [7:0] d2;

        repeat (3) @(negedge clk);
        check("rst_serial",   32'(serial_out), 32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_done",     32'(tx_done),    32'd0);
        check("rst_wr_ready", 32'(wr_ready),   32'd1);
        check("rst_count",    32'(fifo_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // Basic, parity and two-stop frames
        send_and_check(8'hA5, 3, 2'b00, 1'b0);
        send_and_check(8'hA5, 3, 2'b01, 1'b0);
        send_and_check(8'h07, 3, 2'b10, 1'b0);
        send_and_check(8'h00, 0, 2'b00, 1'b1);

        // FIFO full with wr_valid held high for six writes
        for (int i = 0; i < 6; i++) begin
            fd[i]       = 8'($urandom);
            acc_edge[i] = 0;
        end
        baud_div    = 16'd15;
        parity_mode = 2'b00;
        stop_2      = 1'b0;
        fork
            begin : writer
                int   edge_i;
                int   k;
                logic acc;
                edge_i   = 0;
                k        = 0;
                wr_data  = fd[0];
                wr_valid = 1'b1;
                while ((k < 6) && (edge_i < 400)) begin
                    acc = wr_ready;
                    @(posedge clk);
                    edge_i++;
                    if (acc) begin
                        acc_edge[k] = edge_i;
                        k++;
                    end
                    @(negedge clk);
                    if (edge_i == 5) begin
                        check("full_count", 32'(fifo_count), 32'd4);
                        check("full_wr_ready", 32'(wr_ready), 32'd0);
                    end
                    if (k < 6) wr_data = fd[k];
                    else wr_valid = 1'b0;
                end
                wr_valid = 1'b0;
                check("fifo_writes_accepted", 32'(k), 32'd6);
            end
            begin : framer
                wait_start(10);
                for (int i = 0; i < 6; i++) check_frame(fd[i], 15, 2'b00, 1'b0);
                check_idle("fifo_drained");
            end
        join
        for (int i = 0; i < 6; i++) begin
            check("accept_edge", 32'(acc_edge[i]), 32'((i < 5) ? (i + 1) : (2 + 16 * 10 + 1)));
        end

        // Reset in the middle of a DATA bit with two entries still queued
        baud_div = 16'd3;
        wr_data  = 8'h00;
        wr_valid = 1'b1;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_count",  32'(fifo_count), 32'd2);
        check("pre_rst_busy",   32'(busy),       32'd1);
        check("pre_rst_serial", 32'(serial_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_serial",   32'(serial_out), 32'd1);
        check("async_rst_count",    32'(fifo_count), 32'd0);
        check("async_rst_busy",     32'(busy),       32'd0);
        check("async_rst_done",     32'(tx_done),    32'd0);
        check("async_rst_wr_ready", 32'(wr_ready),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(tx_done), 32'd0);
            check("post_rst_line",    32'(serial_out), 32'd1);
        end

        // Divider changed mid-frame applies only to the next frame
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        baud_div = 16'd3;
        wr_data  = d1;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_data = d2;
        @(negedge clk);
        wr_valid = 1'b0;
        fork
            begin
                check_frame(d1, 3, 2'b00, 1'b0);
                check_frame(d2, 7, 2'b00, 1'b0);
                check_idle("runtime_change");
            end
            begin
                repeat (10) @(negedge clk);
                baud_div = 16'd7;
            end
        join

        // Randomized single frames
        for (int i = 0; i < 8; i++) begin
            send_and_check(8'($urandom), int'($urandom_range(0, 3)),
                           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
